reg_wb_arbiter: RTL and testbench

REG_WB_ARBITER -- requirements
Module: reg_wb_arbiter

---
 rtl/reg_pkg.sv | 17 +
 rtl/wb_fifo.sv | 79 +++++++
 rtl/reg_wb_arbiter.sv | 154 +++++++++++++++
 tb/tb_reg_wb_arbiter.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_pkg.sv
// Shared types for the register-file writeback arbiter.
package reg_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_req_t;

  typedef enum logic {
    NORMAL = 1'b0,
    DRAIN  = 1'b1
  } arb_state_t;

endpackage

// File: rtl/wb_fifo.sv
// Small FIFO buffering long-latency writebacks. Every slot's rd and an
// occupancy bit are exported so the decode stage can check hazards
// against results that are still queued.
module wb_fifo
  import reg_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                        clk_i,
  input  logic                        rst_n_i,
  input  logic                        i_push,
  input  wb_req_t                     i_push_req,
  input  logic                        i_pop,
  output wb_req_t                     o_head,
  output logic                        o_full,
  output logic                        o_empty,
  output logic [DEPTH-1:0]            o_ent_vld,
  output logic [DEPTH*REG_ADDR_W-1:0] o_ent_rd
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  wb_req_t         r_mem [DEPTH];
  logic [DEPTH-1:0] r_vld;
  logic [PW-1:0]   r_wptr;
  logic [PW-1:0]   r_rptr;
  logic [CW-1:0]   r_cnt;

  logic w_push;
  logic w_pop;

  assign o_full  = (r_cnt == DEPTH_C);
  assign o_empty = (r_cnt == '0);
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_head  = r_mem[r_rptr];
  assign o_ent_vld = r_vld;

  // Flatten slot rd fields for the hazard comparators.
  always_comb begin
    o_ent_rd = '0;
    for (int i = 0; i < DEPTH; i++) begin
      o_ent_rd[i*REG_ADDR_W +: REG_ADDR_W] = r_mem[i].rd;
    end
  end

  // Storage, pointers and occupancy; pointers wrap at DEPTH (power of two).
  // A push and a pop never touch the same slot: that would need the FIFO
  // to be both empty (no pop) and full (no push).
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_vld  <= '0;
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= i_push_req;
        r_vld[r_wptr] <= 1'b1;
        r_wptr        <= r_wptr + PW'(1);
      end
      if (w_pop) begin
        r_vld[r_rptr] <= 1'b0;
        r_rptr        <= r_rptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/reg_wb_arbiter.sv
// Register-file writeback arbiter. Port A (pipeline) has priority; port B
// (long-latency unit) is always buffered in a FIFO and gets the write port
// when A is idle, or forcibly for one cycle after A has won STARVE_LIMIT
// times in a row while B was waiting.
//
//   state  | meaning
//   -------+---------------------------------------------------------
//   NORMAL | A accepted every cycle; FIFO head written when A is idle
//   DRAIN  | A stalled; FIFO head written, then back to NORMAL
module reg_wb_arbiter
  import reg_pkg::*;
#(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  a_valid_i,
  input  logic [REG_ADDR_W-1:0] a_rd_i,
  input  logic [XLEN-1:0]       a_data_i,
  output logic                  a_ready_o,
  input  logic                  b_valid_i,
  input  logic [REG_ADDR_W-1:0] b_rd_i,
  input  logic [XLEN-1:0]       b_data_i,
  output logic                  b_ready_o,
  input  logic [REG_ADDR_W-1:0] rs1_i,
  input  logic [REG_ADDR_W-1:0] rs2_i,
  output logic                  hazard1_o,
  output logic                  hazard2_o,
  output logic                  wen_o,
  output logic [REG_ADDR_W-1:0] wrd_o,
  output logic [XLEN-1:0]       wdata_o
);

  localparam int SCW = (STARVE_LIMIT < 2) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [SCW-1:0] LIMIT = SCW'(STARVE_LIMIT);

  arb_state_t r_state;
  arb_state_t w_state_nxt;
  logic [SCW-1:0] r_starve;
  logic [SCW-1:0] w_starve_nxt;

  logic                             w_full;
  logic                             w_empty;
  wb_req_t                          w_head;
  wb_req_t                          w_b_req;
  wb_req_t                          w_gnt_req;
  logic [FIFO_DEPTH-1:0]            w_ent_vld;
  logic [FIFO_DEPTH*REG_ADDR_W-1:0] w_ent_rd;
  logic                             w_a_fire;
  logic                             w_b_fire;
  logic                             w_pop;
  logic                             w_grant;
  logic                             w_hz1;
  logic                             w_hz2;

  logic                  r_wen;
  logic [REG_ADDR_W-1:0] r_wrd;
  logic [XLEN-1:0]       r_wdata;

  // Readies are forced low while reset is held.
  assign a_ready_o = rst_n_i & (r_state == NORMAL);
  assign b_ready_o = rst_n_i & ~w_full;
  assign w_a_fire  = a_valid_i & a_ready_o;
  assign w_b_fire  = b_valid_i & b_ready_o;
  assign w_b_req   = '{rd: b_rd_i, data: b_data_i};

  wb_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .i_push     (w_b_fire),
    .i_push_req (w_b_req),
    .i_pop      (w_pop),
    .o_head     (w_head),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_ent_vld  (w_ent_vld),
    .o_ent_rd   (w_ent_rd)
  );

  // FSM state and starve counter registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state  <= NORMAL;
      r_starve <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_starve <= w_starve_nxt;
    end
  end

  // Grant decision, starve counting and next state. DRAIN is left on the
  // pop it exists for; the empty check only guards against a stuck state.
  always_comb begin
    w_state_nxt  = r_state;
    w_pop        = 1'b0;
    w_starve_nxt = r_starve;

    case (r_state)
      NORMAL: w_pop = ~a_valid_i & ~w_empty;
      DRAIN:  w_pop = ~w_empty;
    endcase

    if (w_pop || w_empty) begin
      w_starve_nxt = '0;
    end else if (w_a_fire && (r_starve != LIMIT)) begin
      w_starve_nxt = r_starve + SCW'(1);
    end

    case (r_state)
      NORMAL: if (w_a_fire && !w_empty && (w_starve_nxt == LIMIT)) w_state_nxt = DRAIN;
      DRAIN:  if (w_pop || w_empty) w_state_nxt = NORMAL;
    endcase
  end

  // A and a FIFO pop are mutually exclusive, so at most one grant per cycle.
  assign w_grant   = w_a_fire | w_pop;
  assign w_gnt_req = w_a_fire ? '{rd: a_rd_i, data: a_data_i} : w_head;

  // Register the granted write; rd 0 is a discarded write, addr/data hold idle.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_wen   <= 1'b0;
      r_wrd   <= '0;
      r_wdata <= '0;
    end else begin
      r_wen <= w_grant & (w_gnt_req.rd != '0);
      if (w_grant) begin
        r_wrd   <= w_gnt_req.rd;
        r_wdata <= w_gnt_req.data;
      end
    end
  end

  assign wen_o   = r_wen;
  assign wrd_o   = r_wrd;
  assign wdata_o = r_wdata;

  // Source hazard: match against queued entries or the write in flight.
  always_comb begin
    w_hz1 = r_wen & (r_wrd == rs1_i);
    w_hz2 = r_wen & (r_wrd == rs2_i);
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (w_ent_vld[i] && (w_ent_rd[i*REG_ADDR_W +: REG_ADDR_W] == rs1_i)) w_hz1 = 1'b1;
      if (w_ent_vld[i] && (w_ent_rd[i*REG_ADDR_W +: REG_ADDR_W] == rs2_i)) w_hz2 = 1'b1;
    end
  end

  assign hazard1_o = w_hz1 & (rs1_i != '0);
  assign hazard2_o = w_hz2 & (rs2_i != '0);

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Bench for reg_wb_arbiter: directed scenarios plus a randomized run
// against a queue-based reference model of the arbitration rules.
module tb_reg_wb_arbiter;

  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_valid, b_valid;
  logic [4:0]  a_rd, b_rd, rs1, rs2;
  logic [31:0] a_data, b_data;
  logic        a_ready, b_ready, hazard1, hazard2, wen;
  logic [4:0]  wrd;
  logic [31:0] wdata;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  logic [4:0]  q_rd[$];
  logic [31:0] q_dat[$];
  int          m_starve;
  bit          m_drain;
  logic        m_wen;
  logic [4:0]  m_wrd;
  logic [31:0] m_wdata;

  always #5 clk = ~clk;

  reg_wb_arbiter #(.FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .a_valid_i(a_valid), .a_rd_i(a_rd), .a_data_i(a_data), .a_ready_o(a_ready),
    .b_valid_i(b_valid), .b_rd_i(b_rd), .b_data_i(b_data), .b_ready_o(b_ready),
    .rs1_i(rs1), .rs2_i(rs2), .hazard1_o(hazard1), .hazard2_o(hazard2),
    .wen_o(wen), .wrd_o(wrd), .wdata_o(wdata)
  );

  function automatic logic exp_hz(input logic [4:0] rs);
    if (rs == 5'd0) return 1'b0;
    if (m_wen && (m_wrd == rs)) return 1'b1;
    foreach (q_rd[i]) if (q_rd[i] == rs) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    q_rd.delete();
    q_dat.delete();
    m_starve = 0;
    m_drain  = 0;
    m_wen    = 1'b0;
    m_wrd    = '0;
    m_wdata  = '0;
  endtask

  // One clock cycle: the model applies the arbitration rules to the inputs
  // presented before the edge, then time moves to 1 after the edge.
  task automatic tick();
    bit af, bf, pp, was_drain;
    int sz;
    sz = q_rd.size();
    was_drain = m_drain;
    af = a_valid && !m_drain;
    bf = b_valid && (sz < DEPTH);
    pp = (sz > 0) && (m_drain || !a_valid);
    @(posedge clk);
    if (af) begin
      m_wen = (a_rd != 0); m_wrd = a_rd; m_wdata = a_data;
    end else if (pp) begin
      m_wen = (q_rd[0] != 0); m_wrd = q_rd[0]; m_wdata = q_dat[0];
    end else begin
      m_wen = 1'b0;
    end
    if (pp || sz == 0) m_starve = 0;
    else if (af && m_starve < LIMIT) m_starve = m_starve + 1;
    if (was_drain && pp) m_drain = 0;
    else if (!was_drain && m_starve == LIMIT) m_drain = 1;
    if (pp) begin
      void'(q_rd.pop_front());
      void'(q_dat.pop_front());
    end
    if (bf) begin
      q_rd.push_back(b_rd);
      q_dat.push_back(b_data);
    end
    #1;
  endtask

  task automatic apply_reset();
    a_valid = 0; b_valid = 0;
    rst_n = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0; a_valid = 1; b_valid = 1;
    a_rd = 5'd5; b_rd = 5'd7; a_data = 32'h1; b_data = 32'h2;
    rs1 = 5'd5; rs2 = 5'd7;
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    n_cmp++; if (wen !== 1'b0)  begin n_err++; $display("FAIL rst_wen got=%0b exp=0", wen); end
    n_cmp++; if (wrd !== 5'd0)  begin n_err++; $display("FAIL rst_wrd got=%0d exp=0", wrd); end
    n_cmp++; if (wdata !== 32'd0) begin n_err++; $display("FAIL rst_wdata got=%h exp=0", wdata); end
    n_cmp++; if (a_ready !== 1'b0) begin n_err++; $display("FAIL rst_a_ready got=%0b exp=0", a_ready); end
    n_cmp++; if (b_ready !== 1'b0) begin n_err++; $display("FAIL rst_b_ready got=%0b exp=0", b_ready); end
    n_cmp++; if (hazard1 !== 1'b0 || hazard2 !== 1'b0)
      begin n_err++; $display("FAIL rst_hazard got=%0b%0b exp=00", hazard1, hazard2); end
    a_valid = 0; b_valid = 0;
    @(posedge clk); #1;
    rst_n = 1;
  endtask

  // First handshake right after reset release.
  task automatic test_a_write();
    a_valid = 1; a_rd = 5'd5; a_data = 32'h1234; rs1 = 5'd0; rs2 = 5'd0;
    #1;
    n_cmp++; if (a_ready !== 1'b1) begin n_err++; $display("FAIL aw_ready got=%0b exp=1", a_ready); end
    n_cmp++; if (b_ready !== 1'b1) begin n_err++; $display("FAIL aw_b_ready got=%0b exp=1", b_ready); end
    tick();
    a_valid = 0; rs1 = 5'd5;
    #1;
    n_cmp++; if (wen !== 1'b1) begin n_err++; $display("FAIL aw_wen got=%0b exp=1", wen); end
    n_cmp++; if (wrd !== 5'd5) begin n_err++; $display("FAIL aw_wrd got=%0d exp=5", wrd); end
    n_cmp++; if (wdata !== 32'h1234) begin n_err++; $display("FAIL aw_wdata got=%h exp=1234", wdata); end
    n_cmp++; if (hazard1 !== 1'b1) begin n_err++; $display("FAIL aw_hazard1 got=%0b exp=1", hazard1); end
    tick();
    #1;
    n_cmp++; if (wen !== 1'b0 || wrd !== 5'd5 || wdata !== 32'h1234)
      begin n_err++; $display("FAIL aw_hold got=%0b/%0d/%h exp=0/5/1234", wen, wrd, wdata); end
    n_cmp++; if (hazard1 !== 1'b0) begin n_err++; $display("FAIL aw_hz_clear got=%0b exp=0", hazard1); end
    rs1 = 5'd0;
  endtask

  task automatic test_b_order();
    a_valid = 0; b_valid = 1; b_rd = 5'd7; b_data = 32'hAA;
    #1;
    n_cmp++; if (b_ready !== 1'b1) begin n_err++; $display("FAIL bo_ready1 got=%0b exp=1", b_ready); end
    tick();
    b_rd = 5'd8; b_data = 32'hBB; rs1 = 5'd7;
    #1;
    n_cmp++; if (b_ready !== 1'b1) begin n_err++; $display("FAIL bo_ready2 got=%0b exp=1", b_ready); end
    n_cmp++; if (hazard1 !== 1'b1) begin n_err++; $display("FAIL bo_hz_queued got=%0b exp=1", hazard1); end
    n_cmp++; if (wen !== 1'b0) begin n_err++; $display("FAIL bo_no_bypass got=%0b exp=0", wen); end
    tick();
    b_valid = 0; rs2 = 5'd8;
    #1;
    n_cmp++; if (wen !== 1'b1 || wrd !== 5'd7 || wdata !== 32'hAA)
      begin n_err++; $display("FAIL bo_first got=%0b/%0d/%h exp=1/7/aa", wen, wrd, wdata); end
    n_cmp++; if (hazard2 !== 1'b1) begin n_err++; $display("FAIL bo_hz2 got=%0b exp=1", hazard2); end
    tick();
    #1;
    n_cmp++; if (wen !== 1'b1 || wrd !== 5'd8 || wdata !== 32'hBB)
      begin n_err++; $display("FAIL bo_second got=%0b/%0d/%h exp=1/8/bb", wen, wrd, wdata); end
    tick();
    #1;
    n_cmp++; if (wen !== 1'b0) begin n_err++; $display("FAIL bo_idle got=%0b exp=0", wen); end
    rs1 = 0; rs2 = 0;
  endtask

  task automatic test_starve();
    int n_a;
    a_valid = 1; a_rd = 5'd1; a_data = 32'h101;
    b_valid = 1; b_rd = 5'd9; b_data = 32'h900;
    #1;
    n_cmp++; if (a_ready !== 1'b1 || b_ready !== 1'b1)
      begin n_err++; $display("FAIL st_start got=%0b%0b exp=11", a_ready, b_ready); end
    tick();
    n_a = 0;
    for (int i = 0; i < 16; i++) begin
      b_valid = (i == 0); b_rd = 5'd10; b_data = 32'hA00;
      a_rd = 5'(i + 2); a_data = 32'h100 + i + 2;
      #1;
      if (i == 1) begin
        n_cmp++; if (b_ready !== 1'b0) begin n_err++; $display("FAIL st_full got=%0b exp=0", b_ready); end
      end
      if (a_ready !== 1'b1) break;
      n_a++;
      tick();
    end
    n_cmp++; if (n_a != LIMIT) begin n_err++; $display("FAIL st_a_count got=%0d exp=%0d", n_a, LIMIT); end
    tick();
    #1;
    n_cmp++; if (a_ready !== 1'b1) begin n_err++; $display("FAIL st_resume got=%0b exp=1", a_ready); end
    n_cmp++; if (wen !== 1'b1 || wrd !== 5'd9 || wdata !== 32'h900)
      begin n_err++; $display("FAIL st_drain_wr got=%0b/%0d/%h exp=1/9/900", wen, wrd, wdata); end
    a_valid = 0; b_valid = 0;
    repeat (3) tick();
  endtask

  task automatic test_rd0();
    a_valid = 1; a_rd = 5'd0; a_data = 32'hDEAD; rs1 = 5'd0; rs2 = 5'd0;
    #1;
    n_cmp++; if (a_ready !== 1'b1) begin n_err++; $display("FAIL r0_a_ready got=%0b exp=1", a_ready); end
    tick();
    a_valid = 0; b_valid = 1; b_rd = 5'd0; b_data = 32'hBEEF;
    #1;
    n_cmp++; if (b_ready !== 1'b1) begin n_err++; $display("FAIL r0_b_ready got=%0b exp=1", b_ready); end
    n_cmp++; if (wen !== 1'b0 || hazard1 !== 1'b0)
      begin n_err++; $display("FAIL r0_a_write got=%0b/%0b exp=0/0", wen, hazard1); end
    tick();
    b_valid = 0;
    #1;
    n_cmp++; if (hazard1 !== 1'b0 || hazard2 !== 1'b0)
      begin n_err++; $display("FAIL r0_hz_queued got=%0b%0b exp=00", hazard1, hazard2); end
    tick();
    #1;
    n_cmp++; if (wen !== 1'b0 || hazard1 !== 1'b0)
      begin n_err++; $display("FAIL r0_b_write got=%0b/%0b exp=0/0", wen, hazard1); end
    tick();
  endtask

  task automatic test_reset_mid();
    a_valid = 1; a_rd = 5'd11; a_data = 32'hB0B;
    b_valid = 1; b_rd = 5'd12; b_data = 32'hC0C;
    tick();
    a_rd = 5'd13; b_rd = 5'd14;
    tick();
    rs1 = 5'd12; rs2 = 5'd13;
    #1;
    n_cmp++; if (wen !== 1'b1) begin n_err++; $display("FAIL rm_pre_wen got=%0b exp=1", wen); end
    n_cmp++; if (b_ready !== 1'b0) begin n_err++; $display("FAIL rm_pre_full got=%0b exp=0", b_ready); end
    rst_n = 0;
    #1;
    n_cmp++; if (wen !== 1'b0) begin n_err++; $display("FAIL rm_wen got=%0b exp=0", wen); end
    n_cmp++; if (hazard1 !== 1'b0 || hazard2 !== 1'b0)
      begin n_err++; $display("FAIL rm_hazard got=%0b%0b exp=00", hazard1, hazard2); end
    n_cmp++; if (a_ready !== 1'b0 || b_ready !== 1'b0)
      begin n_err++; $display("FAIL rm_ready got=%0b%0b exp=00", a_ready, b_ready); end
    a_valid = 0; b_valid = 0;
    model_reset();
    @(posedge clk); #1;
    rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++; if (wen !== 1'b0 || b_ready !== 1'b1 || hazard1 !== 1'b0)
        begin n_err++; $display("FAIL rm_after c%0d got=%0b/%0b/%0b exp=0/1/0", i, wen, b_ready, hazard1); end
      tick();
    end
    rs1 = 0; rs2 = 0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      a_valid = ($urandom_range(0, 99) < 55);
      b_valid = ($urandom_range(0, 99) < 50);
      a_rd = 5'($urandom_range(0, 7)); a_data = $urandom;
      b_rd = 5'($urandom_range(0, 7)); b_data = $urandom;
      rs1 = 5'($urandom_range(0, 7)); rs2 = 5'($urandom_range(0, 7));
      #1;
      n_cmp++; if (a_ready !== !m_drain)
        begin n_err++; $display("FAIL rnd_a_ready c%0d got=%0b exp=%0b", c, a_ready, !m_drain); end
      n_cmp++; if (b_ready !== (q_rd.size() < DEPTH))
        begin n_err++; $display("FAIL rnd_b_ready c%0d got=%0b exp=%0b", c, b_ready, q_rd.size() < DEPTH); end
      n_cmp++; if (hazard1 !== exp_hz(rs1))
        begin n_err++; $display("FAIL rnd_hz1 c%0d rs=%0d got=%0b exp=%0b", c, rs1, hazard1, exp_hz(rs1)); end
      n_cmp++; if (hazard2 !== exp_hz(rs2))
        begin n_err++; $display("FAIL rnd_hz2 c%0d rs=%0d got=%0b exp=%0b", c, rs2, hazard2, exp_hz(rs2)); end
      n_cmp++; if (wen !== m_wen)
        begin n_err++; $display("FAIL rnd_wen c%0d got=%0b exp=%0b", c, wen, m_wen); end
      n_cmp++; if (wrd !== m_wrd || wdata !== m_wdata)
        begin n_err++; $display("FAIL rnd_wr c%0d got=%0d/%h exp=%0d/%h", c, wrd, wdata, m_wrd, m_wdata); end
      tick();
    end
    a_valid = 0; b_valid = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_a_write();
    test_b_order();
    test_starve();
    test_rd0();
    test_reset_mid();
    test_random();
    apply_reset();
    rst_n = 1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
